// File: rtl/exstage.sv
// Execute stage: operand select, ALU, NZCV flags, branch resolution,
// stalling multi-cycle multiply, and the E/M pipeline register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no multiply in flight; a MUL request stalls and starts BUSY
// BUSY  | multiply counting down; product handed to E/M when cnt == 0
module exstage #(
  parameter int MUL_CYCLES = 4,
  parameter int W          = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_M,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic         branch_E,
  input  logic         ALUope_E,
  input  logic         flag_E,
  input  logic [3:0]   ALUctrl_E,
  input  logic [3:0]   regScr_E,
  input  logic [W-1:0] regA_E,
  input  logic [W-1:0] regB_E,
  input  logic [W-1:0] inm_E,
  output logic         stall_E,
  output logic         branch_taken_E,
  output logic [W-1:0] pc_target_E,
  output logic [3:0]   flags_o,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic [3:0]   regScr_M,
  output logic [W-1:0] alu_M,
  output logic [W-1:0] wdata_M
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int SW = $clog2(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  mul_a_q, mul_b_q;
  logic [3:0]    flags_q;
  logic          regw_q, memw_q, regmem_q;
  logic [3:0]    regScr_q;
  logic [W-1:0]  alu_q, wdata_q;

  logic [W-1:0]  src_a, src_b, prod, sub_res, result_d;
  logic [W:0]    add_full;
  logic [SW-1:0] shamt;
  logic          c_d, v_d, mul_req, capture;
  logic [3:0]    flags_d;

  assign src_a    = regA_E;
  assign src_b    = ALUope_E ? inm_E : regB_E;
  assign shamt    = src_b[SW-1:0];
  assign add_full = {1'b0, src_a} + {1'b0, src_b};
  assign sub_res  = src_a - src_b;
  assign prod     = mul_a_q * mul_b_q;

  assign mul_req  = (ALUctrl_E == OP_MUL) && !branch_E;
  assign stall_E  = ((state_q == S_IDLE) && mul_req) ||
                    ((state_q == S_BUSY) && (cnt_q != '0));
  assign capture  = !flush_M && !stall_E;

  always_comb begin
    result_d = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    if (branch_E) begin
      result_d = add_full[W-1:0];
    end else begin
      case (ALUctrl_E)
        4'b0000: begin
          result_d = add_full[W-1:0];
          c_d      = add_full[W];
          v_d      = (src_a[W-1] == src_b[W-1]) && (add_full[W-1] != src_a[W-1]);
        end
        4'b0001: begin
          result_d = sub_res;
          c_d      = (src_a >= src_b);
          v_d      = (src_a[W-1] != src_b[W-1]) && (sub_res[W-1] != src_a[W-1]);
        end
        4'b0010: result_d = src_a & src_b;
        4'b0011: result_d = src_a | src_b;
        4'b0100: result_d = src_a ^ src_b;
        4'b0101: result_d = src_a << shamt;
        4'b0110: result_d = src_a >> shamt;
        4'b0111: result_d = W'($signed(src_a) >>> shamt);
        4'b1000: result_d = src_b;
        OP_MUL:  result_d = prod;
        default: result_d = '0;
      endcase
    end
    flags_d = {result_d[W-1], (result_d == '0), c_d, v_d};
  end

  // Branches resolve against the flags already committed, never this op's.
  always_comb begin
    branch_taken_E = 1'b0;
    if (branch_E) begin
      case (ALUctrl_E)
        4'b0000: branch_taken_E = 1'b1;
        4'b0001: branch_taken_E = flags_q[2];
        4'b0010: branch_taken_E = !flags_q[2];
        4'b0011: branch_taken_E = flags_q[3] ^ flags_q[0];
        4'b0100: branch_taken_E = !(flags_q[3] ^ flags_q[0]);
        default: branch_taken_E = 1'b0;
      endcase
    end
  end

  assign pc_target_E = regA_E + inm_E;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      flags_q  <= 4'b0000;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      regmem_q <= 1'b0;
      regScr_q <= '0;
      alu_q    <= '0;
      wdata_q  <= '0;
    end else if (flush_M) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      regmem_q <= 1'b0;
      regScr_q <= '0;
      alu_q    <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (mul_req) begin
          state_q <= S_BUSY;
          cnt_q   <= CNT_LOAD;
          mul_a_q <= src_a;
          mul_b_q <= src_b;
        end
        S_BUSY: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else             state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (capture) begin
        regw_q   <= regw_E;
        memw_q   <= memw_E;
        regmem_q <= regmem_E;
        regScr_q <= regScr_E;
        alu_q    <= result_d;
        wdata_q  <= regB_E;
        if (flag_E && !branch_E) flags_q <= flags_d;
      end else begin
        regw_q   <= 1'b0;
        memw_q   <= 1'b0;
        regmem_q <= 1'b0;
        regScr_q <= '0;
        alu_q    <= '0;
        wdata_q  <= '0;
      end
    end
  end

  assign flags_o  = flags_q;
  assign regw_M   = regw_q;
  assign memw_M   = memw_q;
  assign regmem_M = regmem_q;
  assign regScr_M = regScr_q;
  assign alu_M    = alu_q;
  assign wdata_M  = wdata_q;

endmodule

// File: tb/tb_exstage.sv
// Directed bench for exstage: ALU ops, flags, branches, multiply stall,
// flush and reset during a multiply.
module tb_exstage;

  logic        clk = 1'b0;
  logic        rst, flush_M, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E;
  logic [3:0]  ALUctrl_E, regScr_E;
  logic [31:0] regA_E, regB_E, inm_E;
  logic        stall_E, branch_taken_E, regw_M, memw_M, regmem_M;
  logic [31:0] pc_target_E, alu_M, wdata_M;
  logic [3:0]  flags_o, regScr_M;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exstage #(.MUL_CYCLES(4), .W(32)) dut (
    .clk(clk), .rst(rst), .flush_M(flush_M),
    .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E),
    .branch_E(branch_E), .ALUope_E(ALUope_E), .flag_E(flag_E),
    .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E),
    .regA_E(regA_E), .regB_E(regB_E), .inm_E(inm_E),
    .stall_E(stall_E), .branch_taken_E(branch_taken_E), .pc_target_E(pc_target_E),
    .flags_o(flags_o), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .alu_M(alu_M), .wdata_M(wdata_M)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic br, input logic [3:0] ctrl, input logic ope,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                    input logic rw, input logic fl);
    branch_E = br; ALUctrl_E = ctrl; ALUope_E = ope;
    regA_E = a; regB_E = b; inm_E = imm; regw_E = rw; flag_E = fl;
    memw_E = 1'b0; regmem_E = 1'b0; regScr_E = 4'd0;
  endtask

  task automatic bubble();
    op(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush_M = 1'b0;
    bubble();
    tick(); tick();
    chk("rst_alu", alu_M, 32'h0);
    chk("rst_regw", {31'b0, regw_M}, 32'h0);
    chk("rst_flags", {28'b0, flags_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_E}, 32'h0);

    rst = 1'b0;
    op(1'b0, 4'b0000, 1'b1, 32'h0000FFFF, 32'h0, 32'h1, 1'b1, 1'b1);
    regScr_E = 4'd3;
    tick();
    chk("add_alu", alu_M, 32'h00010000);
    chk("add_regw", {31'b0, regw_M}, 32'h1);
    chk("add_scr", {28'b0, regScr_M}, 32'h3);
    chk("add_flags", {28'b0, flags_o}, 32'h0);

    op(1'b0, 4'b0001, 1'b0, 32'd5, 32'd5, 32'h0, 1'b1, 1'b1);
    tick();
    chk("sub_eq_alu", alu_M, 32'h0);
    chk("sub_eq_flags", {28'b0, flags_o}, 32'h6);
    op(1'b0, 4'b0001, 1'b0, 32'd0, 32'd1, 32'h0, 1'b1, 1'b1);
    tick();
    chk("sub_neg_alu", alu_M, 32'hFFFFFFFF);
    chk("sub_neg_flags", {28'b0, flags_o}, 32'h8);

    // Flags now N=1: EQ not taken, LT taken.
    op(1'b1, 4'b0001, 1'b1, 32'h100, 32'h0, 32'h20, 1'b0, 1'b1);
    #1;
    chk("br_eq_nz", {31'b0, branch_taken_E}, 32'h0);
    chk("br_pc", pc_target_E, 32'h120);
    ALUctrl_E = 4'b0011; #1;
    chk("br_lt", {31'b0, branch_taken_E}, 32'h1);
    tick();
    chk("br_noflag", {28'b0, flags_o}, 32'h8);
    chk("br_alu", alu_M, 32'h120);

    op(1'b0, 4'b0001, 1'b0, 32'd5, 32'd5, 32'h0, 1'b1, 1'b1);
    tick();
    op(1'b1, 4'b0001, 1'b1, 32'h100, 32'h0, 32'h20, 1'b0, 1'b1);
    #1;
    chk("br_eq_z", {31'b0, branch_taken_E}, 32'h1);
    ALUctrl_E = 4'b0010; #1;
    chk("br_ne", {31'b0, branch_taken_E}, 32'h0);
    ALUctrl_E = 4'b0100; #1;
    chk("br_ge", {31'b0, branch_taken_E}, 32'h1);
    ALUctrl_E = 4'b0111; #1;
    chk("br_never", {31'b0, branch_taken_E}, 32'h0);
    ALUctrl_E = 4'b0000; #1;
    chk("br_always", {31'b0, branch_taken_E}, 32'h1);
    tick();
    chk("br_noflag2", {28'b0, flags_o}, 32'h6);

    // MUL 7*6 with flag update; flags must hold during the stall.
    op(1'b0, 4'b1010, 1'b0, 32'd7, 32'd6, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mul_stall%0d", i), {31'b0, stall_E}, 32'h1);
      tick();
      chk($sformatf("mul_alu%0d", i), alu_M, 32'h0);
      chk($sformatf("mul_regw%0d", i), {31'b0, regw_M}, 32'h0);
      chk($sformatf("mul_flg%0d", i), {28'b0, flags_o}, 32'h6);
    end
    chk("mul_stall_end", {31'b0, stall_E}, 32'h0);
    tick();
    chk("mul_alu", alu_M, 32'h2A);
    chk("mul_regw", {31'b0, regw_M}, 32'h1);
    chk("mul_flags", {28'b0, flags_o}, 32'h0);
    chk("mul_idle", {31'b0, stall_E}, 32'h1);

    op(1'b0, 4'b0000, 1'b1, 32'h7FFFFFFF, 32'h0, 32'h1, 1'b1, 1'b1);
    #1;
    chk("post_mul_nostall", {31'b0, stall_E}, 32'h0);
    tick();
    chk("add_ovf_alu", alu_M, 32'h80000000);
    chk("add_ovf_flags", {28'b0, flags_o}, 32'h9);
    op(1'b0, 4'b0000, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b1, 1'b1);
    tick();
    chk("add_cry_alu", alu_M, 32'h0);
    chk("add_cry_flags", {28'b0, flags_o}, 32'h6);
    op(1'b0, 4'b0010, 1'b1, 32'h0000F0F0, 32'h0, 32'h0000FF00, 1'b1, 1'b1);
    tick();
    chk("and_alu", alu_M, 32'h0000F000);
    chk("and_flags", {28'b0, flags_o}, 32'h0);
    op(1'b0, 4'b0111, 1'b1, 32'h80000000, 32'h0, 32'd4, 1'b1, 1'b1);
    tick();
    chk("sra_alu", alu_M, 32'hF8000000);
    chk("sra_flags", {28'b0, flags_o}, 32'h8);
    op(1'b0, 4'b0110, 1'b1, 32'h80000000, 32'h0, 32'd4, 1'b1, 1'b1);
    tick();
    chk("shr_alu", alu_M, 32'h08000000);
    op(1'b0, 4'b0101, 1'b1, 32'h1, 32'h0, 32'd31, 1'b1, 1'b1);
    tick();
    chk("shl_alu", alu_M, 32'h80000000);
    op(1'b0, 4'b0100, 1'b1, 32'hFF, 32'h0, 32'h0F, 1'b1, 1'b1);
    tick();
    chk("xor_alu", alu_M, 32'hF0);
    op(1'b0, 4'b0011, 1'b0, 32'hF0, 32'h0F, 32'h0, 1'b1, 1'b1);
    tick();
    chk("or_alu", alu_M, 32'hFF);
    op(1'b0, 4'b1000, 1'b1, 32'hAAAA, 32'h0, 32'h1234, 1'b1, 1'b1);
    tick();
    chk("mov_alu", alu_M, 32'h1234);
    op(1'b0, 4'b1111, 1'b1, 32'h5, 32'h0, 32'h7, 1'b1, 1'b1);
    tick();
    chk("undef_alu", alu_M, 32'h0);
    chk("undef_flags", {28'b0, flags_o}, 32'h4);

    op(1'b0, 4'b0000, 1'b1, 32'h10, 32'hDEADBEEF, 32'h4, 1'b0, 1'b0);
    memw_E = 1'b1; regmem_E = 1'b1; regScr_E = 4'd9;
    tick();
    chk("st_alu", alu_M, 32'h14);
    chk("st_wdata", wdata_M, 32'hDEADBEEF);
    chk("st_memw", {31'b0, memw_M}, 32'h1);
    chk("st_regmem", {31'b0, regmem_M}, 32'h1);
    chk("st_scr", {28'b0, regScr_M}, 32'h9);
    chk("st_flags", {28'b0, flags_o}, 32'h4);

    bubble();
    tick();
    chk("bub_alu", alu_M, 32'h0);
    chk("bub_memw", {31'b0, memw_M}, 32'h0);
    chk("bub_flags", {28'b0, flags_o}, 32'h4);

    op(1'b0, 4'b0000, 1'b1, 32'h3, 32'h0, 32'h4, 1'b1, 1'b1);
    flush_M = 1'b1;
    tick();
    chk("fl_alu", alu_M, 32'h0);
    chk("fl_regw", {31'b0, regw_M}, 32'h0);
    chk("fl_flags", {28'b0, flags_o}, 32'h4);

    // Abort a MUL in its 2nd BUSY cycle, then rerun it from scratch.
    flush_M = 1'b0;
    op(1'b0, 4'b1010, 1'b0, 32'd3, 32'd3, 32'h0, 1'b1, 1'b1);
    tick(); tick();
    flush_M = 1'b1;
    tick();
    flush_M = 1'b0;
    chk("flm_alu", alu_M, 32'h0);
    chk("flm_regw", {31'b0, regw_M}, 32'h0);
    chk("flm_flags", {28'b0, flags_o}, 32'h4);
    chk("flm_restall", {31'b0, stall_E}, 32'h1);
    bubble(); #1;
    chk("flm_idle", {31'b0, stall_E}, 32'h0);
    tick();
    chk("flm_noprod", alu_M, 32'h0);
    op(1'b0, 4'b1010, 1'b0, 32'd3, 32'd3, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mul2_stall%0d", i), {31'b0, stall_E}, 32'h1);
      tick();
      chk($sformatf("mul2_alu%0d", i), alu_M, 32'h0);
    end
    chk("mul2_stall_end", {31'b0, stall_E}, 32'h0);
    tick();
    chk("mul2_alu", alu_M, 32'h9);
    chk("mul2_flags", {28'b0, flags_o}, 32'h0);

    op(1'b0, 4'b0001, 1'b0, 32'd0, 32'd1, 32'h0, 1'b1, 1'b1);
    tick();
    chk("pre_rst_flags", {28'b0, flags_o}, 32'h8);
    op(1'b0, 4'b1010, 1'b0, 32'd2, 32'd2, 32'h0, 1'b1, 1'b1);
    tick(); tick();
    rst = 1'b1; flush_M = 1'b1;
    tick();
    rst = 1'b0; flush_M = 1'b0;
    chk("rstm_flags", {28'b0, flags_o}, 32'h0);
    chk("rstm_alu", alu_M, 32'h0);
    chk("rstm_regw", {31'b0, regw_M}, 32'h0);
    bubble(); #1;
    chk("rstm_idle", {31'b0, stall_E}, 32'h0);
    tick();
    chk("rstm_noprod", alu_M, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
